// File: rtl/golden_nonce_tx_if.sv
// golden_nonce_tx_if: golden-nonce strobe input and UART/status outputs of the result-return path.
interface golden_nonce_tx_if;
  logic        golden_nonce_valid;
  logic [31:0] golden_nonce;
  logic        tx_serial;
  logic        tx_busy;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  dropped_count;
  modport master (
    output golden_nonce_valid, golden_nonce,
    input  tx_serial, tx_busy, fifo_empty, fifo_full, dropped_count
  );
  modport slave (
    input  golden_nonce_valid, golden_nonce,
    output tx_serial, tx_busy, fifo_empty, fifo_full, dropped_count
  );
endinterface

// File: rtl/golden_nonce_tx.sv
// golden_nonce_tx: buffers golden-nonce hits in a FIFO and sends each word big-endian over UART 8N1.
module golden_nonce_tx #(
  parameter int BAUD_DIV        = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input logic             clk,
  input logic             reset,
  golden_nonce_tx_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = $clog2(BAUD_DIV) + 1;
  localparam int NW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                     r_state, w_next;
  logic [31:0]                r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr, r_rd;
  logic [NW-1:0]              r_count, w_count;
  logic                       r_empty, r_full;
  logic [7:0]                 r_dropped;
  logic [31:0]                r_shift;
  logic [1:0]                 r_byte;
  logic [2:0]                 r_bit;
  logic [CW-1:0]              r_baud;
  logic                       w_push, w_pop, w_tick, w_tx, w_busy;
  // Acceptance looks only at the pre-edge fill level, so a same-edge pop never frees a slot.
  assign w_push  = bus.golden_nonce_valid && !r_full;
  assign w_pop   = r_state == IDLE && !r_empty;
  assign w_tick  = r_baud == '0;
  assign w_count = r_count + NW'(w_push) - NW'(w_pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_dropped <= '0;
    end else begin
      r_wr    <= r_wr + FIFO_DEPTH_LOG2'(w_push);
      r_rd    <= r_rd + FIFO_DEPTH_LOG2'(w_pop);
      r_count <= w_count;
      r_empty <= w_count == '0;
      r_full  <= w_count == NW'(DEPTH);
      if (bus.golden_nonce_valid && r_full && r_dropped != 8'hff) r_dropped <= r_dropped + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr] <= bus.golden_nonce;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pop ? START : IDLE;
      START:   w_next = w_tick ? DATA : START;
      DATA:    w_next = (w_tick && r_bit == 3'd7) ? STOP : DATA;
      default: w_next = w_tick ? (r_byte != 2'd0 ? START : IDLE) : STOP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_byte  <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd];
      r_byte  <= 2'd3;
      r_bit   <= '0;
      r_baud  <= RELOAD;
    end else if (r_state != IDLE) begin
      r_baud <= w_tick ? RELOAD : r_baud - CW'(1);
      if (w_tick && r_state == START) r_bit <= '0;
      if (w_tick && r_state == DATA) r_bit <= r_bit + 3'd1;
      if (w_tick && r_state == STOP && r_byte != 2'd0) r_byte <= r_byte - 2'd1;
    end
  end
  // {byte, bit} indexes the held word directly; byte 3 (MSB) goes out first.
  always_comb begin
    w_tx   = r_state == START ? 1'b0 : r_state == DATA ? r_shift[{r_byte, r_bit}] : 1'b1;
    w_busy = r_state != IDLE;
  end
  assign bus.tx_serial     = w_tx;
  assign bus.tx_busy       = w_busy;
  assign bus.fifo_empty    = r_empty;
  assign bus.fifo_full     = r_full;
  assign bus.dropped_count = r_dropped;
endmodule

// File: tb/tb_golden_nonce_tx.sv
// tb_golden_nonce_tx: directed checks of the golden-nonce UART return path at BAUD_DIV 4 and 1.
module tb_golden_nonce_tx;
  localparam logic [159:0] ONES = {160{1'b1}};
  localparam int W4 = 161;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic rec_tx[$];
  logic rec_busy[$];
  logic rec1_tx[$];
  logic rec1_busy[$];
  golden_nonce_tx_if bus4();
  golden_nonce_tx_if bus1();
  golden_nonce_tx #(.BAUD_DIV(4), .FIFO_DEPTH_LOG2(2)) u4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  golden_nonce_tx #(.BAUD_DIV(1), .FIFO_DEPTH_LOG2(2)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    rec_tx.push_back(bus4.tx_serial);
    rec_busy.push_back(bus4.tx_busy);
    rec1_tx.push_back(bus1.tx_serial);
    rec1_busy.push_back(bus1.tx_busy);
  end
  function automatic logic [159:0] exp_line(input logic [31:0] w, input int b);
    logic [159:0] v;
    logic [9:0]   f;
    int           k;
    v = ONES;
    k = 0;
    for (int i = 3; i >= 0; i--) begin
      f = {1'b1, w[i*8 +: 8], 1'b0};
      for (int j = 0; j < 10; j++)
        for (int r = 0; r < b; r++) begin
          v[k] = f[j];
          k++;
        end
    end
    return v;
  endfunction
  function automatic logic [159:0] rec_slice(input int sel, input int s, input int n);
    logic [159:0] v;
    v = ONES;
    for (int k = 0; k < n; k++)
      v[k] = sel == 0 ? rec_tx[s+k] : sel == 1 ? rec_busy[s+k] : sel == 2 ? rec1_tx[s+k] : rec1_busy[s+k];
    return v;
  endfunction
  task automatic clear_rec;
    rec_tx.delete();
    rec_busy.delete();
    rec1_tx.delete();
    rec1_busy.delete();
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    bus4.golden_nonce_valid = 1'b0;
    bus1.golden_nonce_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    checks++;
    if ({bus4.tx_serial, bus4.tx_busy, bus4.fifo_empty, bus4.fifo_full} !== 4'b1010 || bus4.dropped_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_b4: got tx/busy/empty/full=%b dropped=%0d, expected 1010 dropped=0",
        {bus4.tx_serial, bus4.tx_busy, bus4.fifo_empty, bus4.fifo_full}, bus4.dropped_count);
    end
    checks++;
    if ({bus1.tx_serial, bus1.tx_busy, bus1.fifo_empty, bus1.fifo_full} !== 4'b1010 || bus1.dropped_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_b1: got tx/busy/empty/full=%b dropped=%0d, expected 1010 dropped=0",
        {bus1.tx_serial, bus1.tx_busy, bus1.fifo_empty, bus1.fifo_full}, bus1.dropped_count);
    end
  endtask
  task automatic test_single;
    logic [31:0] w;
    w = 32'h0e33337a;
    do_reset;
    clear_rec;
    bus4.golden_nonce_valid = 1'b1;
    bus4.golden_nonce = w;
    @(negedge clk);
    bus4.golden_nonce_valid = 1'b0;
    checks++;
    if (bus4.tx_serial !== 1'b1 || bus4.fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_pre: got tx=%b empty=%b, expected tx=1 empty=0", bus4.tx_serial, bus4.fifo_empty);
    end
    while (rec_tx.size() < 163) @(negedge clk);
    checks++;
    if (rec_slice(0, 1, 160) !== exp_line(w, 4)) begin
      errors++;
      $display("FAIL single_line: got %h expected %h", rec_slice(0, 1, 160), exp_line(w, 4));
    end
    checks++;
    if (rec_slice(1, 1, 160) !== ONES) begin
      errors++;
      $display("FAIL single_busy: got %h expected %h", rec_slice(1, 1, 160), ONES);
    end
    checks++;
    if (rec_tx[161] !== 1'b1 || rec_busy[161] !== 1'b0 || bus4.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_end: got tx=%b busy=%b empty=%b, expected 1 0 1", rec_tx[161], rec_busy[161], bus4.fifo_empty);
    end
  endtask
  task automatic test_back_to_back;
    do_reset;
    clear_rec;
    for (int i = 1; i <= 4; i++) begin
      bus4.golden_nonce_valid = 1'b1;
      bus4.golden_nonce = 32'(i);
      @(negedge clk);
    end
    bus4.golden_nonce_valid = 1'b0;
    while (rec_tx.size() < 3 * W4 + 163) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rec_slice(0, 1 + k * W4, 160) !== exp_line(32'(k + 1), 4) || rec_slice(1, 1 + k * W4, 160) !== ONES) begin
        errors++;
        $display("FAIL b2b_word%0d: got line %h expected %h", k, rec_slice(0, 1 + k * W4, 160), exp_line(32'(k + 1), 4));
      end
      checks++;
      if (rec_tx[161 + k * W4] !== 1'b1 || rec_busy[161 + k * W4] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d: got tx=%b busy=%b, expected 1 0", k, rec_tx[161 + k * W4], rec_busy[161 + k * W4]);
      end
    end
    checks++;
    if (bus4.dropped_count !== 8'd0 || bus4.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_status: got dropped=%0d empty=%b, expected 0 1", bus4.dropped_count, bus4.fifo_empty);
    end
  endtask
  task automatic test_overflow;
    do_reset;
    clear_rec;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        checks++;
        if (bus4.fifo_empty !== 1'b0 || bus4.fifo_full !== 1'b0) begin
          errors++;
          $display("FAIL ovf_pushpop: got empty=%b full=%b, expected 0 0", bus4.fifo_empty, bus4.fifo_full);
        end
      end
      if (i == 5) begin
        checks++;
        if (bus4.fifo_full !== 1'b1) begin
          errors++;
          $display("FAIL ovf_full: got full=%b expected 1", bus4.fifo_full);
        end
      end
      bus4.golden_nonce_valid = 1'b1;
      bus4.golden_nonce = 32'h11 + 32'(i);
      @(negedge clk);
    end
    bus4.golden_nonce_valid = 1'b0;
    checks++;
    if (bus4.dropped_count !== 8'd1) begin
      errors++;
      $display("FAIL ovf_dropped: got %0d expected 1", bus4.dropped_count);
    end
    while (rec_tx.size() < 4 * W4 + 262) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rec_slice(0, 1 + k * W4, 160) !== exp_line(32'h11 + 32'(k), 4)) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h expected %h", k, rec_slice(0, 1 + k * W4, 160), exp_line(32'h11 + 32'(k), 4));
      end
    end
    checks++;
    if (rec_slice(0, 4 * W4 + 161, 100) !== ONES || rec_slice(1, 4 * W4 + 161, 100) !== (ONES << 100)) begin
      errors++;
      $display("FAIL ovf_no_sixth: got tx %h busy %h, expected idle high and not busy",
        rec_slice(0, 4 * W4 + 161, 100), rec_slice(1, 4 * W4 + 161, 100));
    end
  endtask
  task automatic test_saturate;
    logic [31:0] w;
    do_reset;
    clear_rec;
    for (int i = 0; i < 305; i++) begin
      if (i == 161) begin
        checks++;
        if (bus4.dropped_count !== 8'd156) begin
          errors++;
          $display("FAIL sat_mid: got %0d expected 156", bus4.dropped_count);
        end
      end
      bus4.golden_nonce_valid = 1'b1;
      bus4.golden_nonce = 32'(i + 1);
      @(negedge clk);
    end
    bus4.golden_nonce_valid = 1'b0;
    checks++;
    if (bus4.dropped_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: got %0d expected 255", bus4.dropped_count);
    end
    while (rec_tx.size() < 5 * W4 + 163) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      w = k < 5 ? 32'(k + 1) : 32'd164;
      checks++;
      if (rec_slice(0, 1 + k * W4, 160) !== exp_line(w, 4)) begin
        errors++;
        $display("FAIL sat_word%0d: got %h expected %h", k, rec_slice(0, 1 + k * W4, 160), exp_line(w, 4));
      end
    end
    checks++;
    if (bus4.dropped_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: got %0d expected 255", bus4.dropped_count);
    end
  endtask
  task automatic test_mid_reset;
    logic [159:0] e;
    int           bad;
    e = exp_line(32'ha5c30f69, 4);
    do_reset;
    clear_rec;
    for (int i = 0; i < 3; i++) begin
      bus4.golden_nonce_valid = 1'b1;
      bus4.golden_nonce = i == 0 ? 32'ha5c30f69 : 32'hdead0000 + 32'(i);
      @(negedge clk);
    end
    bus4.golden_nonce_valid = 1'b0;
    while (rec_tx.size() < 59) @(negedge clk);
    checks++;
    if (rec_tx[58] !== e[58] || rec_tx[58] !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit3: got %b expected %b", rec_tx[58], e[58]);
    end
    reset = 1'b1;
    bus4.golden_nonce_valid = 1'b1;
    bus4.golden_nonce = 32'h12345678;
    @(negedge clk);
    reset = 1'b0;
    bus4.golden_nonce_valid = 1'b0;
    checks++;
    if ({bus4.tx_serial, bus4.tx_busy, bus4.fifo_empty, bus4.fifo_full} !== 4'b1010 || bus4.dropped_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_after: got tx/busy/empty/full=%b dropped=%0d, expected 1010 dropped=0",
        {bus4.tx_serial, bus4.tx_busy, bus4.fifo_empty, bus4.fifo_full}, bus4.dropped_count);
    end
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus4.tx_serial !== 1'b1 || bus4.tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL mid_idle: got %0d non-idle cycles expected 0", bad);
    end
  endtask
  task automatic test_baud1;
    do_reset;
    clear_rec;
    bus1.golden_nonce_valid = 1'b1;
    bus1.golden_nonce = 32'hffffffff;
    @(negedge clk);
    bus1.golden_nonce = 32'h00000000;
    @(negedge clk);
    bus1.golden_nonce_valid = 1'b0;
    while (rec1_tx.size() < 84) @(negedge clk);
    checks++;
    if (rec_slice(2, 1, 40) !== exp_line(32'hffffffff, 1) || rec_slice(3, 1, 40) !== ONES) begin
      errors++;
      $display("FAIL b1_ones: got line %h busy %h expected line %h", rec_slice(2, 1, 40), rec_slice(3, 1, 40), exp_line(32'hffffffff, 1));
    end
    checks++;
    if (rec1_tx[41] !== 1'b1 || rec1_busy[41] !== 1'b0) begin
      errors++;
      $display("FAIL b1_gap: got tx=%b busy=%b expected 1 0", rec1_tx[41], rec1_busy[41]);
    end
    checks++;
    if (rec_slice(2, 42, 40) !== exp_line(32'h0, 1) || rec_slice(3, 42, 40) !== ONES) begin
      errors++;
      $display("FAIL b1_zeros: got line %h busy %h expected line %h", rec_slice(2, 42, 40), rec_slice(3, 42, 40), exp_line(32'h0, 1));
    end
    checks++;
    if (rec1_tx[82] !== 1'b1 || rec1_busy[82] !== 1'b0 || bus1.fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL b1_end: got tx=%b busy=%b empty=%b expected 1 0 1", rec1_tx[82], rec1_busy[82], bus1.fifo_empty);
    end
  endtask
  initial begin
    bus4.golden_nonce_valid = 1'b0;
    bus4.golden_nonce = '0;
    bus1.golden_nonce_valid = 1'b0;
    bus1.golden_nonce = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_saturate;
    test_mid_reset;
    test_baud1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
